sram_read_streamer: RTL and testbench

//  Read-side master for the router's sequential SRAM buffer. It accepts a burst command (base address, length) and issues
//  one-per-cycle reads on the SRAM read port. It absorbs the SRAM's 1-cycle read latency and presents the words as a

---
 rtl/sram_read_streamer.sv | 207 ++++++++++++++++++++
 tb/tb_sram_read_streamer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_read_streamer.sv
// Purpose : read-side burst master for the sequential SRAM buffer; turns (base, len) into one-per-cycle
//           SRAM reads and re-times the 1-cycle-latency read data into a valid/ready stream.
// Latency : start accepted at edge 0 -> o_read_en in cycle 1 -> o_valid in cycle 3; 1 word/cycle sustained.
// Backpressure: a 2-entry FIFO plus an in-flight credit stops reads while i_ready=0 so no word is dropped.
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_start, i_base_addr, i_len       burst command (taken only when idle; len 0 gives a bare o_done)
//   o_busy, o_done                    burst in progress / 1-cycle completion pulse
//   o_read_en, o_read_addr            SRAM read port request
//   i_rd_data, i_rd_valid             SRAM read return (one cycle after o_read_en)
//   o_data, o_valid, i_ready          downstream stream (FIFO head)
//   o_last                            final-word marker, present only when SRAM_RD_LAST_EN is defined
module sram_read_streamer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = ADDR_WIDTH * ADDR_WIDTH,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [LEN_WIDTH-1:0]  i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_read_en,
  output logic [ADDR_WIDTH-1:0] o_read_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic                  i_rd_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready
`ifdef SRAM_RD_LAST_EN
  ,
  output logic                  o_last
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_issue_rem;
  logic [LEN_WIDTH-1:0]  r_out_rem;
  logic                  r_inflight;

  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_read_en;
  logic                  w_accept;
  logic [2:0]            w_occ;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;

  assign w_pop  = (r_count != 2'd0) && i_ready;
  // Returns that were requested before a reset have no in-flight credit and are discarded.
  assign w_push = i_rd_valid && r_inflight;

  // Slots already committed after this cycle's pop; a new read needs one free slot of the two.
  assign w_occ = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

  assign w_addr_nxt = (r_addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : r_addr + ADDR_WIDTH'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_read_en   = 1'b0;
    w_accept    = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            w_accept    = 1'b1;
            w_state_nxt = S_ISSUE;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        o_busy = 1'b1;
        if ((r_issue_rem != '0) && (w_occ <= 3'd1)) begin
          w_read_en = 1'b1;
        end
        if (w_read_en && (r_issue_rem == LEN_WIDTH'(1))) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        if (w_pop && (r_out_rem == LEN_WIDTH'(1))) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_read_en   = w_read_en;
  assign o_read_addr = r_addr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr      <= '0;
      r_issue_rem <= '0;
      r_out_rem   <= '0;
      r_inflight  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr      <= i_base_addr;
        r_issue_rem <= i_len;
        r_out_rem   <= i_len;
      end else begin
        if (w_read_en) begin
          r_addr      <= w_addr_nxt;
          r_issue_rem <= r_issue_rem - LEN_WIDTH'(1);
        end
        if (w_pop && (r_out_rem != '0)) begin
          r_out_rem <= r_out_rem - LEN_WIDTH'(1);
        end
      end
      // A new request re-arms the flag in the same cycle the previous return clears it.
      if (w_read_en) begin
        r_inflight <= 1'b1;
      end else if (i_rd_valid) begin
        r_inflight <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_rd_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];

`ifdef SRAM_RD_LAST_EN
  logic r_last [2];
  logic w_push_last;

  // out_rem counts words not yet popped; those not yet in the FIFO number out_rem - count,
  // so the word being pushed is the final one when exactly one remains outside the FIFO.
  assign w_push_last = (r_out_rem == (LEN_WIDTH'(r_count) + LEN_WIDTH'(1)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last[0] <= 1'b0;
      r_last[1] <= 1'b0;
    end else if (w_push) begin
      r_last[r_wr_ptr] <= w_push_last;
    end
  end

  assign o_last = o_valid && r_last[r_rd_ptr];
`endif

  // The credit rule must never let a push land on a full FIFO without a simultaneous pop.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      a_no_overflow: assert (!(w_push && !w_pop && (r_count == 2'd2)));
    end
  end

endmodule

// File: tb/tb_sram_read_streamer.sv
module tb_sram_read_streamer;
  localparam int AW  = 8;
  localparam int DW  = 64;
  localparam int DEP = AW * AW;
  localparam int LW  = AW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic          read_en;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
`ifdef SRAM_RD_LAST_EN
  logic          last;
`endif

  logic [DW-1:0] sram [DEP];
  logic          sram_vld = 1'b0;
  logic [DW-1:0] sram_dat = '0;
  logic          stale_inj = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Behavioural SRAM: one-cycle read latency.
  always @(posedge clk) begin
    sram_vld <= read_en;
    sram_dat <= sram[read_addr[5:0]];
  end

  assign rd_data  = sram_dat;
  assign rd_valid = sram_vld | stale_inj;

  sram_read_streamer dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_base_addr (base_addr),
    .i_len       (len),
    .o_busy      (busy),
    .o_done      (done),
    .o_read_en   (read_en),
    .o_read_addr (read_addr),
    .i_rd_data   (rd_data),
    .i_rd_valid  (rd_valid),
    .o_data      (data),
    .o_valid     (valid),
    .i_ready     (ready)
`ifdef SRAM_RD_LAST_EN
    ,
    .o_last      (last)
`endif
  );

  // mode 0: always ready; 1: ready pattern 1,0,0 repeating; 2: random ready.
  // busy_cyc: cycle at which a second (to-be-ignored) i_start is pulsed, -1 for none.
  task automatic run_burst(input int b, input int n, input int mode, input int busy_cyc, input string nm);
    logic [DW-1:0] exp_dat [$];
    logic [AW-1:0] exp_adr [$];
    logic [DW-1:0] prev_dat;
    int n_iss, n_pop, n_done, done_cyc, first_vld, post;
    bit prev_stall;
    n_iss = 0; n_pop = 0; n_done = 0; done_cyc = -1; first_vld = -1; post = 0;
    prev_stall = 1'b0; prev_dat = '0;
    for (int i = 0; i < n; i++) begin
      exp_adr.push_back(AW'((b + i) % DEP));
      exp_dat.push_back(sram[(b + i) % DEP]);
    end
    for (int cyc = 0; cyc < 80 + n * 6 && post < 3; cyc++) begin
      @(negedge clk);
      start = (cyc == 0) || (cyc == busy_cyc);
      if (cyc == 0) begin
        base_addr = AW'(b);
        len       = LW'(n);
      end else if (cyc == busy_cyc) begin
        base_addr = AW'($urandom_range(0, DEP - 1));
        len       = LW'($urandom_range(1, 20));
      end
      case (mode)
        0:       ready = 1'b1;
        1:       ready = (cyc % 3 == 0);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (read_en) begin
        total++;
        if (n_iss >= n) begin
          bad++;
          $display("FAIL %s extra_read cyc=%0d got addr=%0d, required no read", nm, cyc, read_addr);
        end else if (read_addr !== exp_adr[n_iss]) begin
          bad++;
          $display("FAIL %s read_addr cyc=%0d got=%0d required=%0d", nm, cyc, read_addr, exp_adr[n_iss]);
        end
        n_iss++;
      end
      if (valid) begin
        if (first_vld < 0) first_vld = cyc;
        if (prev_stall) begin
          total++;
          if (data !== prev_dat) begin
            bad++;
            $display("FAIL %s stall_stable cyc=%0d got=%h required=%h", nm, cyc, data, prev_dat);
          end
        end
        if (ready) begin
          total++;
          if (n_pop >= n) begin
            bad++;
            $display("FAIL %s extra_word cyc=%0d got=%h, required none", nm, cyc, data);
          end else if (data !== exp_dat[n_pop]) begin
            bad++;
            $display("FAIL %s data[%0d] cyc=%0d got=%h required=%h", nm, n_pop, cyc, data, exp_dat[n_pop]);
          end
`ifdef SRAM_RD_LAST_EN
          total++;
          if (last !== (n_pop == n - 1)) begin
            bad++;
            $display("FAIL %s last[%0d] got=%b required=%b", nm, n_pop, last, (n_pop == n - 1));
          end
`endif
          n_pop++;
        end
      end
      prev_stall = valid && !ready;
      prev_dat   = data;
      total++;
      if (n_iss - n_pop > 2) begin
        bad++;
        $display("FAIL %s outstanding cyc=%0d got=%0d required<=2", nm, cyc, n_iss - n_pop);
      end
      if (n > 0 && cyc >= 1 && n_done == 0 && !done) begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL %s busy cyc=%0d got=%b required=1", nm, cyc, busy);
        end
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        total++;
        if (busy !== 1'b0 || n_pop != n) begin
          bad++;
          $display("FAIL %s done_state cyc=%0d busy=%b pops=%0d required busy=0 pops=%0d", nm, cyc, busy, n_pop, n);
        end
      end
      if (n_done > 0) post++;
    end
    start = 1'b0;
    total++;
    if (n_done != 1 || n_pop != n || n_iss != n) begin
      bad++;
      $display("FAIL %s totals done=%0d pops=%0d reads=%0d required 1/%0d/%0d", nm, n_done, n_pop, n_iss, n, n);
    end
    if (mode == 0) begin
      total++;
      if (n == 0) begin
        if (done_cyc != 1) begin
          bad++;
          $display("FAIL %s zero_len_done_cyc got=%0d required=1", nm, done_cyc);
        end
      end else if (first_vld != 3 || done_cyc != n + 3) begin
        bad++;
        $display("FAIL %s timing first_valid=%0d done=%0d required 3/%0d", nm, first_vld, done_cyc, n + 3);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({busy, done, read_en, valid} !== 4'b0 || read_addr !== '0 || data !== '0) begin
      bad++;
      $display("FAIL reset busy=%b done=%b rd=%b vld=%b addr=%0d data=%h required all 0",
               busy, done, read_en, valid, read_addr, data);
    end
`ifdef SRAM_RD_LAST_EN
    total++;
    if (last !== 1'b0) begin
      bad++;
      $display("FAIL reset_last got=%b required=0", last);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_burst(5, 4, 0, -1, "basic");
  endtask

  task automatic test_wrap();
    run_burst(62, 4, 0, -1, "wrap");
  endtask

  task automatic test_backpressure();
    run_burst($urandom_range(0, DEP - 1), 8, 1, -1, "backpressure");
  endtask

  task automatic test_zero_len_and_busy_start();
    run_burst($urandom_range(0, DEP - 1), 0, 0, 1, "zero_len");
    run_burst($urandom_range(0, DEP - 1), 6, 0, 2, "busy_start");
  endtask

  task automatic test_reset_mid();
    int n_pop;
    n_pop = 0;
    @(negedge clk);
    start = 1'b1; base_addr = AW'($urandom_range(0, DEP - 1)); len = LW'(10); ready = 1'b1;
    for (int cyc = 1; cyc < 30 && n_pop < 3; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (valid && ready) n_pop++;
    end
    total++;
    if (n_pop != 3) begin
      bad++;
      $display("FAIL reset_mid_pops got=%0d required=3", n_pop);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    stale_inj = 1'b1;
    #1;
    total++;
    if ({busy, done, read_en, valid} !== 4'b0 || read_addr !== '0 || data !== '0) begin
      bad++;
      $display("FAIL reset_mid_clear busy=%b done=%b rd=%b vld=%b addr=%0d data=%h required all 0",
               busy, done, read_en, valid, read_addr, data);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      stale_inj = 1'b0;
      #1;
      total++;
      if (valid !== 1'b0 || done !== 1'b0 || read_en !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid_stale k=%0d vld=%b done=%b rd=%b required 0", k, valid, done, read_en);
      end
    end
    run_burst(0, 2, 0, -1, "after_reset");
  endtask

  task automatic test_last();
    run_burst($urandom_range(0, DEP - 1), 3, 0, -1, "last3");
    run_burst($urandom_range(0, DEP - 1), 1, 2, -1, "last1");
  endtask

  task automatic test_back_to_back_random();
    for (int t = 0; t < 8; t++) begin
      run_burst($urandom_range(0, DEP - 1), $urandom_range(1, 24), 2, -1, "random");
    end
  endtask

  initial begin
    for (int i = 0; i < DEP; i++) sram[i] = {$urandom, $urandom};
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len_and_busy_start();
    test_reset_mid();
    test_last();
    test_back_to_back_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
